// File: rtl/second_phase_database_streamer_if.sv
// -----------------------------------------------------------------------------
// second_phase_database_streamer_if
// Groups the pass-control, ROM and stream signals of the second-phase database
// streamer.
//   master : the streamer side (drives the ROM read, stream word and status)
//   slave  : the environment side (ROM model, consumer, pass requester)
// Signals:
//   i_start               one-cycle pass request
//   o_rom_rd/o_rom_addr   ROM read strobe and word address
//   i_rom_data            ROM data, valid the cycle after o_rom_rd
//   o_valid/i_ready       stream handshake
//   o_data                parameter word
//   o_index_*             database/classifier/tree indices of o_data
//   o_end_*               boundary flags of o_data
//   o_busy/o_done         pass in progress / one-cycle completion pulse
// -----------------------------------------------------------------------------
interface second_phase_database_streamer_if #(
    parameter int DATA_WIDTH_12 = 12,
    parameter int ADDR_WIDTH    = 16
);
    logic                     i_start;
    logic                     o_rom_rd;
    logic [ADDR_WIDTH-1:0]    o_rom_addr;
    logic [DATA_WIDTH_12-1:0] i_rom_data;
    logic                     o_valid;
    logic                     i_ready;
    logic [DATA_WIDTH_12-1:0] o_data;
    logic [DATA_WIDTH_12-1:0] o_index_database;
    logic [DATA_WIDTH_12-1:0] o_index_classifier;
    logic [DATA_WIDTH_12-1:0] o_index_tree;
    logic                     o_end_single_classifier;
    logic                     o_end_all_classifier;
    logic                     o_end_tree;
    logic                     o_end_database;
    logic                     o_busy;
    logic                     o_done;

    modport master (
        input  i_start,
        output o_rom_rd,
        output o_rom_addr,
        input  i_rom_data,
        output o_valid,
        input  i_ready,
        output o_data,
        output o_index_database,
        output o_index_classifier,
        output o_index_tree,
        output o_end_single_classifier,
        output o_end_all_classifier,
        output o_end_tree,
        output o_end_database,
        output o_busy,
        output o_done
    );

    modport slave (
        output i_start,
        input  o_rom_rd,
        input  o_rom_addr,
        output i_rom_data,
        input  o_valid,
        output i_ready,
        input  o_data,
        input  o_index_database,
        input  o_index_classifier,
        input  o_index_tree,
        input  o_end_single_classifier,
        input  o_end_all_classifier,
        input  o_end_tree,
        input  o_end_database,
        input  o_busy,
        input  o_done
    );
endinterface

// File: rtl/second_phase_database_streamer.sv
// -----------------------------------------------------------------------------
// second_phase_database_streamer
// Streams one stage database out of a ROM as a valid/ready word stream, tagging
// every word with its indices and boundary flags.
// Layout per tree: C classifiers x P parameter words, then one threshold word;
// trees are stored back to back from address 0.
// Ports:
//   clk_fpga    sole clock, rising edge
//   reset_fpga  asynchronous active-high reset
//   bus         streamer side of second_phase_database_streamer_if
// Datapath: reads are issued one word per cycle; a read's data lands one cycle
// later and is either handed straight to the consumer or parked in a 2-entry
// skid FIFO. Reads are only issued when the FIFO plus all reads still in
// flight can never exceed two words, which gives zero-bubble resume after a
// stall without losing the in-flight word.
// -----------------------------------------------------------------------------
module second_phase_database_streamer #(
    parameter int DATA_WIDTH_12            = 12,
    parameter int ADDR_WIDTH               = 16,
    parameter int NUM_TREES                = 2,
    parameter int NUM_CLASSIFIERS_PER_TREE = 2,
    parameter int NUM_PARAM_PER_CLASSIFIER = 18
) (
    input  logic clk_fpga,
    input  logic reset_fpga,
    second_phase_database_streamer_if.master bus
);
    localparam int C     = NUM_CLASSIFIERS_PER_TREE;
    localparam int P     = NUM_PARAM_PER_CLASSIFIER;
    localparam int W     = C * P + 1;
    localparam int TOTAL = NUM_TREES * W;

    typedef logic [DATA_WIDTH_12-1:0] word_t;
    typedef logic [ADDR_WIDTH:0]      cnt_t;

    localparam word_t P_LAST    = word_t'(P - 1);
    localparam word_t C_LAST    = word_t'(C - 1);
    localparam word_t C_THR     = word_t'(C);
    localparam word_t T_LAST    = word_t'(NUM_TREES - 1);
    localparam cnt_t  TOTAL_CNT = cnt_t'(TOTAL);

    typedef struct packed {
        word_t idx_db;
        word_t idx_cls;
        word_t idx_tree;
        logic  end_single;
        logic  end_all;
        logic  end_tree;
        logic  end_db;
    } meta_t;

    typedef struct packed {
        word_t data;
        meta_t meta;
    } entry_t;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t                state_q, state_d;
    logic                  rd_q, rd_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    cnt_t                  issue_q, issue_d;      // words issued this pass
    word_t                 p_q, p_d;              // position of next word to issue
    word_t                 c_q, c_d;
    word_t                 t_q, t_d;
    meta_t                 rd_meta_q, rd_meta_d;  // tags of the read on the ROM bus
    meta_t                 fly_meta_q, fly_meta_d;// tags of the data on i_rom_data
    logic                  fly_vld_q, fly_vld_d;
    entry_t                ent0_q, ent0_d;        // skid FIFO head
    entry_t                ent1_q, ent1_d;
    logic [1:0]            cnt_q, cnt_d;          // skid FIFO occupancy
    logic                  done_q, done_d;

    meta_t  cur_meta;
    entry_t in_entry;
    entry_t head;
    entry_t head_out;
    logic   out_vld;
    logic   accept;
    logic   pop;
    logic   push;
    logic   room;
    logic   thr;
    logic [1:0] slot;
    logic [2:0] occ;

    // Tags for the word at the current issue position.
    always_comb begin
        thr                 = (c_q == C_THR);
        cur_meta.idx_db     = thr ? '0 : p_q;
        cur_meta.idx_cls    = c_q;
        cur_meta.idx_tree   = t_q;
        cur_meta.end_single = !thr && (p_q == P_LAST);
        cur_meta.end_all    = !thr && (p_q == P_LAST) && (c_q == C_LAST);
        cur_meta.end_tree   = thr;
        cur_meta.end_db     = thr && (t_q == T_LAST);
    end

    // Output selection: FIFO head when non-empty, otherwise bypass the ROM data.
    always_comb begin
        in_entry.data = bus.i_rom_data;
        in_entry.meta = fly_meta_q;
        out_vld       = (cnt_q != 2'd0) || fly_vld_q;
        head          = (cnt_q != 2'd0) ? ent0_q : in_entry;
        head_out      = out_vld ? head : '0;
        accept        = out_vld && bus.i_ready;
        pop           = accept && (cnt_q != 2'd0);
        // Incoming data is parked unless it was taken directly this cycle.
        push          = fly_vld_q && !(accept && (cnt_q == 2'd0));
        cnt_d         = cnt_q + {1'b0, push} - {1'b0, pop};
        slot          = cnt_q - {1'b0, pop};
        // Words that will be buffered or arriving next cycle; a new read is only
        // safe while that leaves one slot for it.
        occ           = {1'b0, cnt_d} + {2'b00, rd_q};
        room          = (occ < 3'd2);
    end

    always_comb begin
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        if (pop) begin
            ent0_d = ent1_q;
        end
        if (push) begin
            if (slot == 2'd0) begin
                ent0_d = in_entry;
            end else begin
                ent1_d = in_entry;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        rd_d       = 1'b0;
        addr_d     = addr_q;
        issue_d    = issue_q;
        p_d        = p_q;
        c_d        = c_q;
        t_d        = t_q;
        rd_meta_d  = rd_meta_q;
        fly_meta_d = rd_meta_q;
        fly_vld_d  = rd_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Issue counters are zero in IDLE, so word 0 goes out at once.
                if (bus.i_start) begin
                    state_d = S_RUN;
                    rd_d    = 1'b1;
                end
            end
            S_RUN: begin
                if (accept && head.meta.end_db) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else if ((issue_q < TOTAL_CNT) && room) begin
                    rd_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (rd_d) begin
            addr_d    = issue_q[ADDR_WIDTH-1:0];
            rd_meta_d = cur_meta;
            issue_d   = issue_q + cnt_t'(1);
            if (thr) begin
                p_d = '0;
                c_d = '0;
                t_d = t_q + word_t'(1);
            end else if (p_q == P_LAST) begin
                p_d = '0;
                c_d = c_q + word_t'(1);
            end else begin
                p_d = p_q + word_t'(1);
            end
        end

        if (done_d) begin
            issue_d = '0;
            p_d     = '0;
            c_d     = '0;
            t_d     = '0;
        end
    end

    always_ff @(posedge clk_fpga or posedge reset_fpga) begin
        if (reset_fpga) begin
            state_q    <= S_IDLE;
            rd_q       <= 1'b0;
            addr_q     <= '0;
            issue_q    <= '0;
            p_q        <= '0;
            c_q        <= '0;
            t_q        <= '0;
            rd_meta_q  <= '0;
            fly_meta_q <= '0;
            fly_vld_q  <= 1'b0;
            ent0_q     <= '0;
            ent1_q     <= '0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_q       <= rd_d;
            addr_q     <= addr_d;
            issue_q    <= issue_d;
            p_q        <= p_d;
            c_q        <= c_d;
            t_q        <= t_d;
            rd_meta_q  <= rd_meta_d;
            fly_meta_q <= fly_meta_d;
            fly_vld_q  <= fly_vld_d;
            ent0_q     <= ent0_d;
            ent1_q     <= ent1_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
        end
    end

    assign bus.o_rom_rd                = rd_q;
    assign bus.o_rom_addr              = addr_q;
    assign bus.o_valid                 = out_vld;
    assign bus.o_data                  = head_out.data;
    assign bus.o_index_database        = head_out.meta.idx_db;
    assign bus.o_index_classifier      = head_out.meta.idx_cls;
    assign bus.o_index_tree            = head_out.meta.idx_tree;
    assign bus.o_end_single_classifier = head_out.meta.end_single;
    assign bus.o_end_all_classifier    = head_out.meta.end_all;
    assign bus.o_end_tree              = head_out.meta.end_tree;
    assign bus.o_end_database          = head_out.meta.end_db;
    assign bus.o_busy                  = (state_q == S_RUN);
    assign bus.o_done                  = done_q;
endmodule

// File: tb/tb_second_phase_database_streamer.sv
// -----------------------------------------------------------------------------
// tb_second_phase_database_streamer
// Directed bench for the database streamer with C=2, P=3, NUM_TREES=2
// (14 words, ROM[a] = 0x100 + a). Outputs are sampled and inputs driven on the
// falling clock edge.
// -----------------------------------------------------------------------------
module tb_second_phase_database_streamer;
    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    second_phase_database_streamer_if #(.DATA_WIDTH_12(12), .ADDR_WIDTH(16)) bus ();

    second_phase_database_streamer #(
        .DATA_WIDTH_12(12),
        .ADDR_WIDTH(16),
        .NUM_TREES(2),
        .NUM_CLASSIFIERS_PER_TREE(2),
        .NUM_PARAM_PER_CLASSIFIER(3)
    ) dut (
        .clk_fpga(clk),
        .reset_fpga(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM model: registered read, data valid the cycle after the strobe.
    always @(posedge clk) begin
        if (bus.o_rom_rd) begin
            bus.i_rom_data <= 12'h100 + bus.o_rom_addr[11:0];
        end
    end

    // Hand-computed tags of words 0..13: {end_single, end_all, end_tree, end_db}
    logic [31:0] exp_db   [14] = '{0,1,2,0,1,2,0, 0,1,2,0,1,2,0};
    logic [31:0] exp_cls  [14] = '{0,0,0,1,1,1,2, 0,0,0,1,1,1,2};
    logic [31:0] exp_tree [14] = '{0,0,0,0,0,0,0, 1,1,1,1,1,1,1};
    logic [31:0] exp_flag [14] = '{4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b0000,
                                   4'b1100, 4'b0010, 4'b0000, 4'b0000, 4'b1000,
                                   4'b0000, 4'b0000, 4'b1100, 4'b0011};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] flags_now();
        return {28'd0, bus.o_end_single_classifier, bus.o_end_all_classifier,
                bus.o_end_tree, bus.o_end_database};
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_rom_rd"}, 32'(bus.o_rom_rd), 32'd0);
        check({tag, "_rom_addr"}, 32'(bus.o_rom_addr), 32'd0);
        check({tag, "_valid"}, 32'(bus.o_valid), 32'd0);
        check({tag, "_data"}, 32'(bus.o_data), 32'd0);
        check({tag, "_idx_db"}, 32'(bus.o_index_database), 32'd0);
        check({tag, "_idx_cls"}, 32'(bus.o_index_classifier), 32'd0);
        check({tag, "_idx_tree"}, 32'(bus.o_index_tree), 32'd0);
        check({tag, "_flags"}, flags_now(), 32'd0);
        check({tag, "_busy"}, 32'(bus.o_busy), 32'd0);
        check({tag, "_done"}, 32'(bus.o_done), 32'd0);
    endtask

    initial begin
        int idx;
        int passes;
        int cyc;
        int words;
        int dones;

        rst         = 1'b1;
        bus.i_start = 1'b0;
        bus.i_ready = 1'b0;

        // Reset state
        @(negedge clk);
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle_valid", 32'(bus.o_valid), 32'd0);
        check("idle_rom_rd", 32'(bus.o_rom_rd), 32'd0);
        $display("step reset: done");

        // Pass A: i_ready held high, full sequence with tags and timing
        bus.i_ready = 1'b1;
        bus.i_start = 1'b1;                       // cycle T
        @(negedge clk);                           // T+1
        bus.i_start = 1'b0;
        check("a_rom_rd", 32'(bus.o_rom_rd), 32'd1);
        check("a_rom_addr", 32'(bus.o_rom_addr), 32'd0);
        check("a_busy", 32'(bus.o_busy), 32'd1);
        check("a_valid_early", 32'(bus.o_valid), 32'd0);
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);                       // T+2+k
            check("a_valid", 32'(bus.o_valid), 32'd1);
            check("a_data", 32'(bus.o_data), 32'h100 + 32'(k));
            check("a_idx_db", 32'(bus.o_index_database), exp_db[k]);
            check("a_idx_cls", 32'(bus.o_index_classifier), exp_cls[k]);
            check("a_idx_tree", 32'(bus.o_index_tree), exp_tree[k]);
            check("a_flags", flags_now(), exp_flag[k]);
            check("a_busy_run", 32'(bus.o_busy), 32'd1);
            check("a_done_early", 32'(bus.o_done), 32'd0);
        end
        @(negedge clk);                           // T+16
        check("a_done", 32'(bus.o_done), 32'd1);
        check("a_busy_end", 32'(bus.o_busy), 32'd0);
        check("a_valid_end", 32'(bus.o_valid), 32'd0);
        @(negedge clk);                           // T+17
        check("a_done_pulse", 32'(bus.o_done), 32'd0);
        $display("step pass A: 14 words streamed");

        // Pass B: stall 5 cycles on word 0x103, zero-bubble resume
        bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        idx = 0;
        for (int n = 2; n <= 20; n++) begin
            @(negedge clk);
            bus.i_ready = !(n >= 5 && n < 10);
            check("b_valid", 32'(bus.o_valid), 32'd1);
            check("b_data", 32'(bus.o_data), 32'h100 + 32'(idx));
            check("b_flags", flags_now(), exp_flag[idx]);
            if (bus.i_ready) idx++;
        end
        @(negedge clk);
        check("b_done", 32'(bus.o_done), 32'd1);
        $display("step pass B: stall and resume");

        // Pass C: random i_ready, 3 passes, each restarted in the o_done cycle
        bus.i_start = 1'b1;
        passes = 0;
        idx    = 0;
        cyc    = 0;
        while (passes < 3 && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            bus.i_start = 1'b0;
            bus.i_ready = 1'($urandom_range(0, 1));
            if (bus.o_rom_rd) check("c_addr_bound", 32'(bus.o_rom_addr < 16'd14), 32'd1);
            if (bus.o_valid) begin
                check("c_data", 32'(bus.o_data), 32'h100 + 32'(idx));
                if (bus.i_ready) idx++;
            end
            if (bus.o_done) begin
                check("c_words", 32'(idx), 32'd14);
                passes++;
                idx = 0;
                $display("step pass C: random pass %0d complete", passes);
                if (passes < 3) bus.i_start = 1'b1;
            end
        end
        check("c_passes", 32'(passes), 32'd3);

        // Pass D: i_start pulsed mid-run is ignored
        bus.i_ready = 1'b1;
        bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        idx   = 0;
        words = 0;
        dones = 0;
        for (int n = 2; n <= 25; n++) begin
            @(negedge clk);
            bus.i_start = (n == 6);
            if (bus.o_valid) begin
                check("d_data", 32'(bus.o_data), 32'h100 + 32'(idx));
                idx++;
                words++;
            end
            if (bus.o_done) dones++;
        end
        bus.i_start = 1'b0;
        check("d_words", 32'(words), 32'd14);
        check("d_dones", 32'(dones), 32'd1);
        $display("step pass D: words=%0d dones=%0d", words, dones);

        // Pass E: reset mid-pass at word 0x108
        @(negedge clk);
        bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        for (int n = 2; n <= 10; n++) begin
            @(negedge clk);
            check("e_data", 32'(bus.o_data), 32'h100 + 32'(n - 2));
        end
        rst = 1'b1;
        #1;
        check_all_zero("e_rst_imm");
        @(negedge clk);
        check_all_zero("e_rst_hold");
        rst = 1'b0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            check("e_post_valid", 32'(bus.o_valid), 32'd0);
            check("e_post_rom_rd", 32'(bus.o_rom_rd), 32'd0);
        end
        bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        check("e_restart_rd", 32'(bus.o_rom_rd), 32'd1);
        check("e_restart_addr", 32'(bus.o_rom_addr), 32'd0);
        @(negedge clk);
        check("e_restart_valid", 32'(bus.o_valid), 32'd1);
        check("e_restart_data", 32'(bus.o_data), 32'h100);
        $display("step pass E: reset mid-pass and restart");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/second_phase_database_streamer.md
SECOND_PHASE_DATABASE_STREAMER -- requirements
Module: second_phase_database_streamer

Interface
REQ-001 SHALL have parameter DATA_WIDTH_12, 12, ROM word and index width.
REQ-002 SHALL have parameter ADDR_WIDTH, 16, ROM address width.
REQ-003 SHALL have parameter NUM_TREES, 2, trees per stage database.
REQ-004 SHALL have parameter NUM_CLASSIFIERS_PER_TREE, 2, classifiers per tree.
REQ-005 SHALL have parameter NUM_PARAM_PER_CLASSIFIER, 18, words per classifier.
REQ-006 SHALL have ports, in this order:
- clk_fpga, in, 1, sole clock; rising edge.
- reset_fpga, in, 1, asynchronous, active-high reset.
- i_start, in, 1, one-cycle pass request.
- o_rom_rd, out, 1, ROM read strobe.
- o_rom_addr, out, ADDR_WIDTH, ROM word address.
- i_rom_data, in, DATA_WIDTH_12, ROM data; valid exactly one cycle after the o_rom_rd cycle.
- o_valid, out, 1, stream word valid.
- i_ready, in, 1, consumer accepts the word.
- o_data, out, DATA_WIDTH_12, parameter word.
- o_index_database, out, DATA_WIDTH_12, word index within classifier.
- o_index_classifier, out, DATA_WIDTH_12, classifier index within tree.
- o_index_tree, out, DATA_WIDTH_12, tree index.
- o_end_single_classifier, o_end_all_classifier, o_end_tree, o_end_database, out, 1 each, boundary flags.
- o_busy, out, 1, pass in progress.
- o_done, out, 1, one-cycle pass-complete pulse.

Function
REQ-007 SHALL use this layout: W = C*P+1 words per tree (C classifiers x P params, then 1 threshold word); TOTAL = NUM_TREES*W; addresses 0..TOTAL-1, contiguous.
REQ-008 SHALL use states IDLE and RUN; IDLE->RUN when i_start is sampled high; RUN->IDLE on acceptance (o_valid&&i_ready) of word TOTAL-1.
REQ-009 SHALL ignore i_start while in RUN; a pass is never restarted mid-stream.
REQ-010 SHALL issue address 0 with o_rom_rd=1 at T+1 when i_start is sampled at T, and present word 0 with o_valid=1 at T+2.
REQ-011 SHALL, with i_ready held high, present word k at cycle T+2+k with no bubbles.
REQ-012 SHALL hold o_data, the indices and the flags stable while o_valid&&!i_ready.
REQ-013 SHALL present the next word in the cycle after i_ready returns high: zero-bubble resume, no word lost or duplicated (skid storage absorbs the in-flight ROM read).
REQ-014 SHALL never issue a ROM read that skid storage cannot hold, and never address beyond TOTAL-1.
REQ-015 SHALL set, on a classifier word, o_index_database = param 0..P-1, o_index_classifier = 0..C-1, o_index_tree = 0..NUM_TREES-1.
REQ-016 SHALL set, on a threshold word, o_index_database=0, o_index_classifier=C, and o_index_tree = current tree.
REQ-017 SHALL assert o_end_single_classifier on param P-1 of every classifier.
REQ-018 SHALL assert o_end_all_classifier on param P-1 of classifier C-1.
REQ-019 SHALL assert o_end_tree on each threshold word.
REQ-020 SHALL assert o_end_database only on word TOTAL-1, together with o_end_tree.
REQ-021 SHALL hold o_busy high from T+1 through the cycle of final acceptance.
REQ-022 SHALL pulse o_done for one cycle, the cycle after final acceptance.
REQ-023 SHALL accept i_start in the o_done cycle and start a new pass from address 0.
REQ-024 SHALL drive o_valid=0 and o_rom_rd=0 in IDLE.

Reset
REQ-025 SHALL, while reset_fpga is high, immediately force IDLE, clear skid storage, and drive every output 0, including o_rom_addr, o_data, the indices and the flags.
REQ-026 SHALL, on reset asserted mid-pass, abandon the pass; after release, no word is output until a new i_start, and that pass restarts at address 0.

Verification (C=2, P=3, NUM_TREES=2, W=7, TOTAL=14; ROM[a]=0x100+a)
REQ-027 SHALL cover: i_start at T with i_ready=1 -> words 0x100..0x10D at T+2..T+15; o_done at T+16; o_busy low at T+16.
REQ-028 SHALL cover: flags on that pass -> end_single at words 2,5,9,12; end_all at 5,12; end_tree at 6,13; end_database only at 13. Word 6 has index_classifier=2, index_database=0, index_tree=0.
REQ-029 SHALL cover: i_ready=0 for 5 cycles while word 0x103 is shown -> 0x103 held stable; 0x104 appears the cycle after i_ready rises; full sequence intact.
REQ-030 SHALL cover: i_ready random 50% over 3 passes -> each accepted sequence equals 0x100..0x10D exactly.
REQ-031 SHALL cover: i_start pulsed during RUN -> ignored; exactly 14 words and one o_done.
REQ-032 SHALL cover: reset_fpga asserted at word 0x108 -> all outputs 0 during reset; next i_start yields 0x100 first.
